// File: rtl/lac_pkg.sv
// Shared types and legal parameter ranges for the LAC phase tracker.
// Latency: n/a; backpressure: n/a.
package lac_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lac_state_t;

   localparam int RATIO_MIN      = 2;
   localparam int RATIO_MAX      = 16;
   localparam int SYNC_MIN       = 2;
   localparam int SYNC_MAX       = 4;
   localparam int LOCK_EDGES_MIN = 1;
   localparam int LOCK_EDGES_MAX = 15;
   localparam int ERR_W_MIN      = 1;

   // Wide enough for every good-edge count up to LOCK_EDGES_MAX.
   localparam int GOOD_W = 4;

endpackage

// File: rtl/lac_sync.sv
// Synchronises the slow LAC clock into the fast domain and flags its rising edge.
// Latency: edge_det rises SYNC_STAGES cycles after lac_in is first sampled high; no backpressure.
module lac_sync
   import lac_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic lac_in,
   output logic edge_det
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_last;
   logic                   prev_q;

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("lac_sync: SYNC_STAGES must be within 2..4");
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], lac_in};
         prev_q <= sync_last;
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign edge_det  = sync_last & ~prev_q;

endmodule

// File: rtl/lac_phase_tracker.sv
// Locks a fast-clock phase counter to the slow LAC clock and emits one strobe per slow period.
// Latency: strobe/locked registered, one cycle after the FSM decision; no backpressure.
module lac_phase_tracker
   import lac_pkg::*;
#(
   parameter int RATIO        = 4,
   parameter int STROBE_PHASE = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_EDGES   = 4,
   parameter int ERR_W        = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     lac_in,
   input  logic                     err_clear,
   output logic                     strobe,
   output logic [$clog2(RATIO)-1:0] phase,
   output logic                     locked,
   output logic [ERR_W-1:0]         err_count
);

   localparam int PH_W = $clog2(RATIO);

   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(RATIO - 1);
   localparam logic [PH_W-1:0]   PH_STROBE = PH_W'(STROBE_PHASE);
   localparam logic [GOOD_W:0]   LOCK_TGT  = (GOOD_W + 1)'(LOCK_EDGES);
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

   if ((RATIO % 2) != 0 || RATIO < RATIO_MIN || RATIO > RATIO_MAX) begin : g_bad_ratio
      $error("lac_phase_tracker: RATIO must be even and within 2..16");
   end
   if (STROBE_PHASE < 0 || STROBE_PHASE >= RATIO) begin : g_bad_strobe
      $error("lac_phase_tracker: STROBE_PHASE must be within 0..RATIO-1");
   end
   if (LOCK_EDGES < LOCK_EDGES_MIN || LOCK_EDGES > LOCK_EDGES_MAX) begin : g_bad_lock
      $error("lac_phase_tracker: LOCK_EDGES must be within 1..15");
   end
   if (ERR_W < ERR_W_MIN) begin : g_bad_err_w
      $error("lac_phase_tracker: ERR_W must be at least 1");
   end

   logic              edge_det;

   lac_state_t        state_q;
   lac_state_t        state_nxt;
   logic [PH_W-1:0]   phase_q;
   logic [PH_W-1:0]   phase_nxt;
   logic [GOOD_W-1:0] good_q;
   logic [GOOD_W-1:0] good_nxt;
   logic [GOOD_W:0]   good_inc;
   logic [ERR_W-1:0]  err_nxt;
   logic              err_inc;
   logic              strobe_nxt;
   logic              locked_nxt;

   logic              at_last;
   logic              on_time;
   logic              early;
   logic              missing;

   lac_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .lac_in   (lac_in),
      .edge_det (edge_det)
   );

   // Edge classification is relative to the phase the counter currently holds.
   assign at_last  = (phase_q == PH_LAST);
   assign on_time  = edge_det &  at_last;
   assign early    = edge_det & ~at_last;
   assign missing  = ~edge_det & at_last;
   assign good_inc = {1'b0, good_q} + (GOOD_W + 1)'(1);

   always_comb begin
      state_nxt = state_q;
      phase_nxt = at_last ? '0 : phase_q + PH_W'(1);
      good_nxt  = good_q;
      err_inc   = 1'b0;

      case (state_q)
         HUNT: begin
            if (edge_det) begin
               phase_nxt = '0;
               good_nxt  = GOOD_W'(1);
               state_nxt = VERIFY;
            end
         end
         VERIFY: begin
            if (on_time) begin
               good_nxt = good_inc[GOOD_W-1:0];
               if (good_inc >= LOCK_TGT) begin
                  state_nxt = LOCKED;
               end
            end else if (early) begin
               phase_nxt = '0;
               good_nxt  = GOOD_W'(1);
            end else if (missing) begin
               state_nxt = HUNT;
            end
         end
         LOCKED: begin
            if (early) begin
               err_inc   = 1'b1;
               phase_nxt = '0;
               good_nxt  = GOOD_W'(1);
               state_nxt = VERIFY;
            end else if (missing) begin
               err_inc   = 1'b1;
               state_nxt = HUNT;
            end
         end
         default: begin
            state_nxt = HUNT;
         end
      endcase
   end

   // A clear coinciding with a loss still records that loss.
   always_comb begin
      err_nxt = err_count;
      if (err_clear) begin
         err_nxt = err_inc ? ERR_W'(1) : '0;
      end else if (err_inc && (err_count != ERR_MAX)) begin
         err_nxt = err_count + ERR_W'(1);
      end
   end

   assign locked_nxt = (state_nxt == LOCKED);
   assign strobe_nxt = locked_nxt && (phase_nxt == PH_STROBE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= HUNT;
         phase_q   <= '0;
         good_q    <= '0;
         err_count <= '0;
         strobe    <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         phase_q   <= phase_nxt;
         good_q    <= good_nxt;
         err_count <= err_nxt;
         strobe    <= strobe_nxt;
         locked    <= locked_nxt;
      end
   end

   assign phase = phase_q;

endmodule

// File: tb/tb_lac_phase_tracker.sv
// Directed bench for lac_phase_tracker: default, ERR_W=2 and RATIO=8 instances share lac_in.
// Idle instances are held in reset while another one is exercised.
module tb_lac_phase_tracker;

   logic       clk = 1'b0;
   logic       lac = 1'b0;
   logic       err_clear = 1'b0;
   logic       rst_a = 1'b0;
   logic       rst_b = 1'b0;
   logic       rst_c = 1'b0;

   logic       strobe_a, locked_a;
   logic [1:0] phase_a;
   logic [7:0] err_a;
   logic       strobe_b, locked_b;
   logic [1:0] phase_b;
   logic [1:0] err_b;
   logic       strobe_c, locked_c;
   logic [2:0] phase_c;
   logic [7:0] err_c;

   int checks = 0;
   int errors = 0;
   int sa = 0;
   int sc = 0;

   always #5 clk = ~clk;

   lac_phase_tracker u_a (
      .clock (clk), .reset_n (rst_a), .lac_in (lac), .err_clear (err_clear),
      .strobe (strobe_a), .phase (phase_a), .locked (locked_a), .err_count (err_a)
   );

   lac_phase_tracker #(.ERR_W(2)) u_b (
      .clock (clk), .reset_n (rst_b), .lac_in (lac), .err_clear (err_clear),
      .strobe (strobe_b), .phase (phase_b), .locked (locked_b), .err_count (err_b)
   );

   lac_phase_tracker #(.RATIO(8), .STROBE_PHASE(7), .LOCK_EDGES(1)) u_c (
      .clock (clk), .reset_n (rst_c), .lac_in (lac), .err_clear (err_clear),
      .strobe (strobe_c), .phase (phase_c), .locked (locked_c), .err_count (err_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one lac_in sample, let one posedge capture it, then sample outputs.
   task automatic step(input logic v);
      lac = v;
      @(posedge clk);
      #1;
      if (strobe_a === 1'b1) sa++;
      if (strobe_c === 1'b1) sc++;
   endtask

   task automatic period4();
      step(1'b1); step(1'b1); step(1'b0); step(1'b0);
   endtask

   task automatic period8();
      repeat (4) step(1'b1);
      repeat (4) step(1'b0);
   endtask

   // From a freshly reset/hunting state: four rising edges, the last one is one step away.
   task automatic lock_seq();
      period4(); period4(); period4();
      step(1'b1); step(1'b1);
   endtask

   task automatic round_b(input logic clr_on_loss, input int exp_err, input int prev_err);
      lock_seq();
      chk("b_prelock", 32'(locked_b), 0);
      step(1'b0);
      chk("b_locked", 32'(locked_b), 1);
      step(1'b0); step(1'b0); step(1'b0);
      chk("b_err_hold", 32'(err_b), 32'(prev_err));
      err_clear = clr_on_loss;
      step(1'b0);
      err_clear = 1'b0;
      chk("b_loss_unlock", 32'(locked_b), 0);
      chk("b_err_count", 32'(err_b), 32'(exp_err));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("a_rst_strobe", 32'(strobe_a), 0);
      chk("a_rst_phase",  32'(phase_a),  0);
      chk("a_rst_locked", 32'(locked_a), 0);
      chk("a_rst_err",    32'(err_a),    0);
      chk("c_rst_phase",  32'(phase_c),  0);
      rst_a = 1'b1;

      // Clean period-4 input: lock on the fourth edge, strobe at phase 2
      lock_seq();
      chk("a_prelock", 32'(locked_a), 0);
      step(1'b0);
      chk("a_lock", 32'(locked_a), 1);
      chk("a_lock_phase", 32'(phase_a), 0);
      step(1'b0);
      chk("a_strobe_ph1", 32'(strobe_a), 0);
      chk("a_phase1", 32'(phase_a), 1);
      step(1'b1);
      chk("a_strobe_ph2", 32'(strobe_a), 1);
      chk("a_phase2", 32'(phase_a), 2);
      step(1'b1);
      chk("a_strobe_ph3", 32'(strobe_a), 0);
      step(1'b0); step(1'b0);
      sa = 0;
      period4(); period4();
      chk("a_strobe_cnt", 32'(sa), 2);
      chk("a_err_clean", 32'(err_a), 0);

      // One-cycle-early edge while locked
      step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b1);
      chk("a_pre_early_strobe", 32'(strobe_a), 1);
      chk("a_pre_early_locked", 32'(locked_a), 1);
      step(1'b0);
      chk("a_early_err", 32'(err_a), 1);
      chk("a_early_unlock", 32'(locked_a), 0);
      chk("a_early_strobe", 32'(strobe_a), 0);
      chk("a_early_phase", 32'(phase_a), 0);
      step(1'b0);
      period4(); period4();
      step(1'b1); step(1'b1);
      chk("a_early_prerelock", 32'(locked_a), 0);
      step(1'b0);
      chk("a_early_relock", 32'(locked_a), 1);
      step(1'b0);
      chk("a_early_err_keep", 32'(err_a), 1);

      // Clear, then hold lac_in low: missing edge
      err_clear = 1'b1;
      step(1'b0);
      err_clear = 1'b0;
      chk("a_clear_err", 32'(err_a), 0);
      chk("a_last_strobe", 32'(strobe_a), 1);
      step(1'b0);
      chk("a_miss_pre_locked", 32'(locked_a), 1);
      step(1'b0);
      chk("a_miss_unlock", 32'(locked_a), 0);
      chk("a_miss_err", 32'(err_a), 1);
      chk("a_miss_phase", 32'(phase_a), 0);
      sa = 0;
      repeat (9) step(1'b0);
      period4(); period4(); period4();
      step(1'b1); step(1'b1);
      chk("a_hunt_no_strobe", 32'(sa), 0);
      chk("a_hunt_prelock", 32'(locked_a), 0);
      step(1'b0);
      chk("a_hunt_relock", 32'(locked_a), 1);
      step(1'b0);
      chk("a_hunt_err_keep", 32'(err_a), 1);

      // One-cycle reset pulse while locked
      rst_a = 1'b0;
      #1;
      chk("a_rstp_locked", 32'(locked_a), 0);
      chk("a_rstp_phase",  32'(phase_a),  0);
      chk("a_rstp_err",    32'(err_a),    0);
      chk("a_rstp_strobe", 32'(strobe_a), 0);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      lock_seq();
      chk("a_rstp_prelock", 32'(locked_a), 0);
      step(1'b0);
      chk("a_rstp_relock", 32'(locked_a), 1);
      chk("a_rstp_relock_phase", 32'(phase_a), 0);
      chk("a_rstp_err_zero", 32'(err_a), 0);
      rst_a = 1'b0;

      // ERR_W=2: saturation at 3, clear coinciding with a loss gives 1
      step(1'b0); step(1'b0);
      rst_b = 1'b1;
      round_b(1'b0, 1, 0);
      round_b(1'b0, 2, 1);
      round_b(1'b0, 3, 2);
      round_b(1'b0, 3, 3);
      round_b(1'b0, 3, 3);
      round_b(1'b1, 1, 3);
      rst_b = 1'b0;

      // RATIO=8, STROBE_PHASE=7, LOCK_EDGES=1
      step(1'b0); step(1'b0);
      rst_c = 1'b1;
      period8();
      step(1'b1); step(1'b1);
      chk("c_prelock", 32'(locked_c), 0);
      step(1'b1);
      chk("c_lock_2nd_edge", 32'(locked_c), 1);
      chk("c_lock_phase", 32'(phase_c), 0);
      step(1'b1);
      repeat (4) step(1'b0);
      step(1'b1);
      chk("c_strobe_ph6", 32'(strobe_c), 0);
      chk("c_phase6", 32'(phase_c), 6);
      step(1'b1);
      chk("c_strobe_ph7", 32'(strobe_c), 1);
      chk("c_phase7", 32'(phase_c), 7);
      step(1'b1);
      chk("c_strobe_ph0", 32'(strobe_c), 0);
      chk("c_phase0", 32'(phase_c), 0);
      chk("c_still_locked", 32'(locked_c), 1);
      sc = 0;
      step(1'b1);
      repeat (4) step(1'b0);
      period8();
      step(1'b1); step(1'b1); step(1'b1);
      chk("c_strobe_cnt", 32'(sc), 2);
      chk("c_err", 32'(err_c), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lac_phase_tracker.md
LAC_PHASE_TRACKER -- requirements
Module: lac_phase_tracker

Interface
REQ-001 Parameter RATIO, default 4: fast-clock cycles per slow period; even, 2..16.
REQ-002 Parameter STROBE_PHASE, default 2: phase at which strobe fires; 0..RATIO-1.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth on lac_in; 2..4.
REQ-004 Parameter LOCK_EDGES, default 4: consecutive on-time edges needed to lock; 1..15.
REQ-005 Parameter ERR_W, default 8: error counter width.
REQ-006 Ports: clock input 1: fast clock, the only clock; all flops on posedge.
REQ-007 Ports: reset_n input 1: asynchronous, active-low reset.
REQ-008 Ports: lac_in input 1: logic-accessible slow clock, nominally RATIO/2 cycles high then RATIO/2 cycles low; asynchronous to clock phase.
REQ-009 Ports: err_clear input 1: synchronous clear of err_count.
REQ-010 Ports: strobe output 1: one-cycle pulse per slow period, only while locked.
REQ-011 Ports: phase output $clog2(RATIO): current phase within the slow period.
REQ-012 Ports: locked output 1: high in state LOCKED.
REQ-013 Ports: err_count output ERR_W: saturating count of lock losses.

Function
REQ-014 lac_in passes through a SYNC_STAGES flop chain, then one further flop; edge_det is high in the cycle where the last sync flop is 1 and the further flop is 0.
REQ-015 Phase counter increments modulo RATIO every cycle; in the cycle after edge_det it is 0 when the FSM accepts the edge; phase output is this register.
REQ-016 On-time edge: edge_det high while phase == RATIO-1. Early edge: edge_det high while phase != RATIO-1. Missing edge: phase == RATIO-1 with edge_det low.
REQ-017 FSM states HUNT, VERIFY, LOCKED; the good-edge counter counts on-time edges.
REQ-018 HUNT: the phase counter free-runs; edge_det loads phase 0 and good-edge count 1, and the FSM goes to VERIFY.
REQ-019 VERIFY: an on-time edge increments the good-edge count; on reaching LOCK_EDGES the FSM goes to LOCKED.
REQ-020 VERIFY: an early edge reloads phase 0 and good-edge count 1 and the FSM stays in VERIFY.
REQ-021 VERIFY: a missing edge sends the FSM to HUNT; err_count is not changed.
REQ-022 LOCKED: an on-time edge keeps the FSM in LOCKED.
REQ-023 LOCKED: an early edge increments err_count, reloads phase 0 and good-edge count 1, and the FSM goes to VERIFY.
REQ-024 LOCKED: a missing edge increments err_count and the FSM goes to HUNT.
REQ-025 With LOCK_EDGES=1, the first edge in HUNT goes to VERIFY and the next on-time edge locks.
REQ-026 strobe is registered: high exactly in cycles where the registered state is LOCKED and phase == STROBE_PHASE; no strobe is emitted in the exit cycle of LOCKED.
REQ-027 locked is registered and equals (state == LOCKED); it drops the cycle after a lock-loss event.
REQ-028 err_count saturates at 2^ERR_W-1 and does not wrap.
REQ-029 err_clear zeroes err_count; if err_clear and an increment occur in the same cycle, err_count becomes 1.
REQ-030 Glitches in lac_in shorter than one clock period either produce no edge_det or are handled as early or missing edges; no other handling applies.

Reset
REQ-031 reset_n low asynchronously clears the sync chain, edge flop, phase, good-edge count, err_count, strobe and locked to 0 and sets state HUNT.
REQ-032 Reset mid-lock loses lock; err_count is not incremented; relock follows REQ-018 and REQ-019 after release.
REQ-033 Reset deassertion is synchronised externally; the block adds no deassertion logic.

Structure
REQ-034 Package lac_pkg holds the state enum (HUNT, VERIFY, LOCKED) and the parameter-range limits.
REQ-035 Sub-module lac_sync implements the SYNC_STAGES synchroniser plus edge detect and outputs edge_det.
REQ-036 Elaboration fails for odd RATIO, or for STROBE_PHASE >= RATIO.

Verification
REQ-037 Defaults, clean lac_in period 4: locked rises after the 4th on-time edge; strobe then every 4 cycles with phase == 2; err_count stays 0.
REQ-038 Locked, then shift lac_in one cycle early: err_count = 1, locked low next cycle, relock after 4 further clean edges.
REQ-039 Locked, then hold lac_in low: err_count = 1, state HUNT, no strobe until clean edges resume and 4 on-time edges are seen.
REQ-040 ERR_W=2, force 5 lock losses: err_count stops at 3; err_clear on the same cycle as a 6th loss gives 1.
REQ-041 reset_n pulsed low for 1 cycle while locked: all outputs 0 immediately; err_count stays 0; relock as in REQ-037.
REQ-042 RATIO=8, STROBE_PHASE=7, LOCK_EDGES=1: locked on the 2nd edge; strobe on the cycle before each phase-0 cycle.
